// File: rtl/quad_cmd_pkg.sv
// Shared QuadCopter command definitions: opcodes, frame length, assembler states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package quad_cmd_pkg;

    // Opcodes understood by the command FSM; the assembler passes them through unchecked
    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    // Bytes per command frame: opcode, data high, data low
    localparam int FRAME_LEN = 3;

    // Assembler position within a frame
    typedef enum logic [1:0] {
        ASM_IDLE = 2'd0,
        ASM_HIGH = 2'd1,
        ASM_LOW  = 2'd2
    } asm_state_e;

endpackage

// File: rtl/uart_cmd_assembler.sv
// Collects opcode/high/low UART bytes into one command word with an inter-byte timeout.
// Latency: cmd/data/cmd_rdy valid the cycle after the edge accepting the third byte.
// Backpressure: none; every rx_rdy byte is consumed immediately, an unread frame is overwritten (ovrn).
module uart_cmd_assembler
    import quad_cmd_pkg::*;
#(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frm_drop,
    output logic        ovrn
);

    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'(ASM_IDLE);
    localparam logic [1:0] S_HIGH = 2'(ASM_HIGH);
    localparam logic [1:0] S_LOW  = 2'(ASM_LOW);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    op_sh;
    logic [7:0]    hi_sh;

    // Every presented byte is consumed in the same cycle, in all states and during reset
    assign clr_rx_rdy = rx_rdy;

    // Frame FSM, shadow registers, output registers and inter-byte timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_sh    <= 8'h00;
            hi_sh    <= 8'h00;
            cmd      <= 8'h00;
            data     <= 16'h0000;
            cmd_rdy  <= 1'b0;
            frm_drop <= 1'b0;
            ovrn     <= 1'b0;
        end else begin
            frm_drop <= 1'b0;
            ovrn     <= 1'b0;
            // Acknowledge clears the flag unless a completing frame below re-sets it
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (rx_rdy) begin
                        op_sh <= rx_data;
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (rx_rdy) begin
                        hi_sh <= rx_data;
                        cnt   <= '0;
                        state <= S_LOW;
                    end else if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        frm_drop <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LOW: begin
                    if (rx_rdy) begin
                        cmd     <= op_sh;
                        data    <= {hi_sh, rx_data};
                        cmd_rdy <= 1'b1;
                        // A frame lost only if the consumer has not acknowledged it this cycle
                        ovrn    <= cmd_rdy & ~clr_cmd_rdy;
                        cnt     <= '0;
                        state   <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        frm_drop <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: directed spec scenarios then randomized traffic vs a queue model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_uart_cmd_assembler;
    import quad_cmd_pkg::*;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frm_drop;
    logic        ovrn;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the frame in progress, silence since last byte, output image
    logic [7:0]  m_q[$];
    int          m_silence;
    logic [7:0]  m_cmd;
    logic [15:0] m_data;
    logic        m_rdy;
    logic        m_drop;
    logic        m_ovrn;
    int          n_drop;
    int          n_ovrn;
    int          n_frames;

    uart_cmd_assembler #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .data       (data),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .frm_drop   (frm_drop),
        .ovrn       (ovrn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_silence = 0;
        m_cmd  = 8'h00;
        m_data = 16'h0000;
        m_rdy  = 1'b0;
        m_drop = 1'b0;
        m_ovrn = 1'b0;
    endtask

    // One clock of the frame rules: three bytes make a frame, TO silent cycles kill a partial one
    task automatic model_step(input logic rx, input logic [7:0] d, input logic clr);
        m_drop = 1'b0;
        m_ovrn = 1'b0;
        if (rx) begin
            m_q.push_back(d);
            m_silence = 0;
            if (m_q.size() == FRAME_LEN) begin
                m_ovrn = m_rdy && !clr;
                m_cmd  = m_q[0];
                m_data = {m_q[1], m_q[2]};
                m_rdy  = 1'b1;
                m_q.delete();
                n_frames++;
            end else if (clr) begin
                m_rdy = 1'b0;
            end
        end else begin
            if (clr) m_rdy = 1'b0;
            if (m_q.size() > 0) begin
                m_silence++;
                if (m_silence == TO) begin
                    m_drop = 1'b1;
                    m_q.delete();
                    m_silence = 0;
                end
            end
        end
        if (m_drop) n_drop++;
        if (m_ovrn) n_ovrn++;
    endtask

    // Drive one cycle of inputs, advance one edge, compare every output with the model
    task automatic cycle(input logic rx, input logic [7:0] d, input logic clr);
        rx_rdy = rx;
        rx_data = d;
        clr_cmd_rdy = clr;
        #1;
        chk("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, rx});
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(rx, d, clr);
        #1;
        chk("cmd",      {24'd0, cmd},      {24'd0, m_cmd});
        chk("data",     {16'd0, data},     {16'd0, m_data});
        chk("cmd_rdy",  {31'd0, cmd_rdy},  {31'd0, m_rdy});
        chk("frm_drop", {31'd0, frm_drop}, {31'd0, m_drop});
        chk("ovrn",     {31'd0, ovrn},     {31'd0, m_ovrn});
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        cycle(1'b1, a, 1'b0);
        cycle(1'b1, b, 1'b0);
        cycle(1'b1, c, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int pulses;
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        clr_cmd_rdy = 1'b0;
        n_drop = 0;
        n_ovrn = 0;
        n_frames = 0;
        model_reset();

        // Reset, with rx_rdy high on one cycle to see clr_rx_rdy follow it
        rst_n = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        chk("rst_cmd",  {24'd0, cmd},     32'h00);
        chk("rst_data", {16'd0, data},    32'h0000);
        chk("rst_rdy",  {31'd0, cmd_rdy}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic frame, three consume pulses
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            rx_rdy = 1'b1;
            #1;
            if (clr_rx_rdy) pulses++;
            cycle(1'b1, (i == 0) ? SET_PTCH : ((i == 1) ? 8'h12 : 8'h34), 1'b0);
        end
        chk("dir_pulses", pulses, 3);
        chk("dir_cmd",  {24'd0, cmd},     32'h02);
        chk("dir_data", {16'd0, data},    32'h1234);
        chk("dir_rdy",  {31'd0, cmd_rdy}, 32'd1);
        idle(2);
        chk("dir_rdy_hold", {31'd0, cmd_rdy}, 32'd1);

        // Acknowledge clears flag, payload held
        cycle(1'b0, 8'h00, 1'b1);
        chk("clr_rdy",  {31'd0, cmd_rdy}, 32'd0);
        chk("clr_cmd",  {24'd0, cmd},     32'h02);
        chk("clr_data", {16'd0, data},    32'h1234);
        idle(1);

        // Timeout: drop exactly TO edges after the second accept
        cycle(1'b1, SET_THRST, 1'b0);
        cycle(1'b1, 8'hAB, 1'b0);
        idle(TO - 1);
        chk("to_before", {31'd0, frm_drop}, 32'd0);
        idle(1);
        chk("to_drop", {31'd0, frm_drop}, 32'd1);
        idle(1);
        chk("to_single", {31'd0, frm_drop}, 32'd0);
        send3(REQ_BATT, 8'h00, 8'h00);
        chk("resync_cmd",  {24'd0, cmd},     32'h01);
        chk("resync_data", {16'd0, data},    32'h0000);
        chk("resync_rdy",  {31'd0, cmd_rdy}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);

        // Byte arriving in the timeout cycle is accepted, no drop
        cycle(1'b1, EMER_LAND, 1'b0);
        idle(TO - 1);
        cycle(1'b1, 8'h9A, 1'b0);
        chk("edge_nodrop", {31'd0, frm_drop}, 32'd0);
        cycle(1'b1, 8'hBC, 1'b0);
        chk("edge_cmd",  {24'd0, cmd},  32'h07);
        chk("edge_data", {16'd0, data}, 32'h9ABC);
        cycle(1'b0, 8'h00, 1'b1);

        // Overrun: second frame without acknowledge
        send3(SET_YAW, 8'hFF, 8'h00);
        chk("ov_first", {31'd0, ovrn}, 32'd0);
        send3(SET_ROLL, 8'h00, 8'h80);
        chk("ov_pulse", {31'd0, ovrn},    32'd1);
        chk("ov_cmd",   {24'd0, cmd},     32'h03);
        chk("ov_data",  {16'd0, data},    32'h0080);
        chk("ov_rdy",   {31'd0, cmd_rdy}, 32'd1);
        idle(1);
        chk("ov_single", {31'd0, ovrn}, 32'd0);

        // Completion in the same cycle as acknowledge
        cycle(1'b1, CALIBRATE, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b1);
        chk("race_rdy",  {31'd0, cmd_rdy}, 32'd1);
        chk("race_ovrn", {31'd0, ovrn},    32'd0);
        chk("race_data", {16'd0, data},    32'h1122);
        cycle(1'b0, 8'h00, 1'b1);

        // Reset mid-frame
        send3(SET_PTCH, 8'h77, 8'h66);
        cycle(1'b1, SET_YAW, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        chk("mrst_cmd",  {24'd0, cmd},     32'h00);
        chk("mrst_data", {16'd0, data},    32'h0000);
        chk("mrst_rdy",  {31'd0, cmd_rdy}, 32'd0);
        send3(MTRS_OFF, 8'h00, 8'h00);
        chk("mrst_new_cmd",  {24'd0, cmd},  32'h08);
        chk("mrst_new_data", {16'd0, data}, 32'h0000);

        // Randomized traffic: short gaps, occasional timeouts near the boundary, random acks
        n_drop = 0;
        n_ovrn = 0;
        n_frames = 0;
        for (int k = 0; k < 600; k++) begin
            int gap;
            if ($urandom_range(0, 19) == 0) gap = $urandom_range(TO - 3, TO + 3);
            else gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++)
                cycle(1'b0, 8'h00, ($urandom_range(0, 9) == 0));
            cycle(1'b1, 8'($urandom), ($urandom_range(0, 5) == 0));
        end
        idle(TO + 2);
        chk("rnd_frames_seen", {31'd0, (n_frames > 0)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_assembler.md
# uart_cmd_assembler

Frame assembler between the UART byte receiver and the command decoder in the QuadCopter DUT. It collects three consecutive received bytes (opcode, data high byte, data low byte) into one command word and presents it to the command FSM with a ready/clear handshake. An inter-byte timeout discards partial frames so the link resynchronises after a dropped byte. It does not interpret opcodes.

## Interface
Parameters:
- TIMEOUT, default 1_000_000: inter-byte timeout in clk cycles (20 ms at 50 MHz). Legal range ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- rx_rdy  in  1  byte available from UART receiver; level, held until consumed
- rx_data  in  8  received byte, valid while rx_rdy=1
- clr_rx_rdy  out  1  consume pulse to receiver, combinational
- cmd  out  8  opcode of last complete frame
- data  out  16  payload of last complete frame, {byte1, byte2}
- cmd_rdy  out  1  complete frame available
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
- frm_drop  out  1  one-cycle pulse: partial frame discarded on timeout
- ovrn  out  1  one-cycle pulse: frame completed while cmd_rdy already 1

## Operation
- States: IDLE (await opcode), HIGH (await data high), LOW (await data low).
- Byte accept: any cycle with rx_rdy=1. clr_rx_rdy = rx_rdy, in every state; exactly one byte per rx_rdy assertion because the receiver drops rx_rdy on that edge.
- IDLE + accept → store opcode in shadow register, go HIGH.
- HIGH + accept → store high byte in shadow register, go LOW.
- LOW + accept → cmd ← shadow opcode, data ← {shadow high, rx_data}, cmd_rdy ← 1, go IDLE. If cmd_rdy was already 1: outputs are overwritten by the new frame, ovrn pulses.
- cmd/data change only on frame completion; they never show a partial frame and hold after clr_cmd_rdy.
- clr_cmd_rdy=1 → cmd_rdy ← 0 at next edge. Completion in the same cycle wins: cmd_rdy stays 1, no ovrn.
- Timeout counter, width $clog2(TIMEOUT): cleared on every byte accept and in IDLE; increments each cycle in HIGH/LOW without rx_rdy. At counter==TIMEOUT-1 with no rx_rdy → go IDLE, counter ← 0, frm_drop ← 1 for one cycle. Shadow registers, cmd, data, cmd_rdy unaffected.
- Byte arriving in the timeout cycle: byte accepted normally, no drop.
- Opcode values are not checked; any byte in IDLE starts a frame.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, cmd=8'h00, data=16'h0000, cmd_rdy=0, frm_drop=0, ovrn=0, counter=0, shadow registers 0. clr_rx_rdy follows rx_rdy even during reset (receiver is reset too).
- Reset mid-frame discards the partial frame; the next byte is treated as an opcode.
- Latency: cmd_rdy, cmd, data valid the cycle after the edge accepting the third byte.
- frm_drop is high during the cycle starting TIMEOUT edges after the edge that accepted the last byte (or entered HIGH/LOW).
- ovrn and frm_drop are registered, single-cycle, never both high in one cycle.
- Back-to-back bytes (rx_rdy high on consecutive cycles) are accepted at full rate.

## Structure
- Shared package quad_cmd_pkg: opcode localparams REQ_BATT 8'h01, SET_PTCH 8'h02, SET_ROLL 8'h03, SET_YAW 8'h04, SET_THRST 8'h05, CALIBRATE 8'h06, EMER_LAND 8'h07, MTRS_OFF 8'h08; frame length constant 3; assembler state enum.
- No sub-module; timeout counter and FSM are inline. Package is also used by the command FSM and the bench.

## Test plan
- Bytes 8'h02, 8'h12, 8'h34 on consecutive cycles → one cycle after third accept: cmd=8'h02, data=16'h1234, cmd_rdy=1; three clr_rx_rdy pulses.
- Then clr_cmd_rdy for one cycle → cmd_rdy=0 next cycle, cmd=8'h02, data=16'h1234 held.
- TIMEOUT=100: bytes 8'h05, 8'hAB, then silence → frm_drop pulse 100 cycles after second accept; then 8'h01, 8'h00, 8'h00 → cmd=8'h01, data=16'h0000, no misalignment.
- Frames {8'h04,8'hFF,8'h00} then {8'h03,8'h00,8'h80} without clr → ovrn pulse at second completion; cmd=8'h03, data=16'h0080, cmd_rdy=1.
- Third byte accepted in same cycle as clr_cmd_rdy → cmd_rdy remains 1, new values present, ovrn=0.
- rst_n low one cycle after two bytes of a frame → all outputs reset values; next 8'h08, 8'h00, 8'h00 → cmd=8'h08, data=16'h0000.
